// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: drives PLL RESETB/BYPASS, qualifies LOCK, and
// releases the system reset once lock has been stable long enough.
module pll_lock_sequencer #(
  parameter int unsigned RESET_CYCLES        = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned POST_LOCK_CYCLES    = 256,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_resetb,
  output logic       pll_bypass,
  output logic       sys_reset,
  output logic       locked,
  output logic       failed,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  localparam int unsigned MAX_A = (RESET_CYCLES > LOCK_STABLE_CYCLES) ?
                                  RESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_B = (LOCK_TIMEOUT_CYCLES > POST_LOCK_CYCLES) ?
                                  LOCK_TIMEOUT_CYCLES : POST_LOCK_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW = $clog2(MAX_ALL) + 1;

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    sync;
  logic          lock_s;
  // {pll_resetb, pll_bypass, sys_reset, locked, failed}
  logic [4:0]    outs_q;

  assign lock_s = sync[1];
  assign {pll_resetb, pll_bypass, sys_reset, locked, failed} = outs_q;

  // Counter value loaded on entry; the state exits when it has counted to zero.
  function automatic logic [CW-1:0] entry_count(input state_t s);
    case (s)
      S_HOLD:      return CW'(RESET_CYCLES - 1);
      S_WAIT_LOCK: return CW'(LOCK_TIMEOUT_CYCLES - 1);
      S_STABLE:    return CW'(LOCK_STABLE_CYCLES - 1);
      S_RELEASE:   return CW'(POST_LOCK_CYCLES - 1);
      S_FAIL:      return CW'(POST_LOCK_CYCLES - 1);
      default:     return '0;
    endcase
  endfunction

  function automatic logic [4:0] state_outputs(input state_t s);
    case (s)
      S_WAIT_LOCK, S_STABLE, S_RELEASE: return 5'b10100;
      S_RUN:                            return 5'b10010;
      S_FAIL:                           return 5'b01101;
      default:                          return 5'b00100;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync            <= 2'b00;
      state           <= S_HOLD;
      cnt             <= CW'(RESET_CYCLES - 1);
      outs_q          <= 5'b00100;
      retry_count     <= '0;
      lock_loss_count <= '0;
    end else begin
      sync <= {sync[0], pll_lock};
      if (cnt != '0) cnt <= cnt - CW'(1);

      // Software relock overrides every other transition; ignored while in HOLD.
      if (relock_req && state != S_HOLD) begin
        retry_count <= '0;
        state       <= S_HOLD;
        cnt         <= entry_count(S_HOLD);
        outs_q      <= state_outputs(S_HOLD);
      end else begin
        case (state)
          S_HOLD: begin
            if (cnt == '0) begin
              state  <= S_WAIT_LOCK;
              cnt    <= entry_count(S_WAIT_LOCK);
              outs_q <= state_outputs(S_WAIT_LOCK);
            end
          end
          S_WAIT_LOCK: begin
            if (lock_s) begin
              state  <= S_STABLE;
              cnt    <= entry_count(S_STABLE);
              outs_q <= state_outputs(S_STABLE);
            end else if (cnt == '0) begin
              if (retry_count < 4'(MAX_RETRIES)) begin
                retry_count <= retry_count + 4'd1;
                state       <= S_HOLD;
                cnt         <= entry_count(S_HOLD);
                outs_q      <= state_outputs(S_HOLD);
              end else begin
                state  <= S_FAIL;
                cnt    <= entry_count(S_FAIL);
                outs_q <= state_outputs(S_FAIL);
              end
            end
          end
          S_STABLE: begin
            if (!lock_s) begin
              state  <= S_WAIT_LOCK;
              cnt    <= entry_count(S_WAIT_LOCK);
              outs_q <= state_outputs(S_WAIT_LOCK);
            end else if (cnt == '0) begin
              state  <= S_RELEASE;
              cnt    <= entry_count(S_RELEASE);
              outs_q <= state_outputs(S_RELEASE);
            end
          end
          S_RELEASE: begin
            if (!lock_s) begin
              state  <= S_WAIT_LOCK;
              cnt    <= entry_count(S_WAIT_LOCK);
              outs_q <= state_outputs(S_WAIT_LOCK);
            end else if (cnt == '0) begin
              retry_count <= '0;
              state       <= S_RUN;
              cnt         <= entry_count(S_RUN);
              outs_q      <= state_outputs(S_RUN);
            end
          end
          S_RUN: begin
            if (!lock_s) begin
              if (lock_loss_count != 8'hFF) lock_loss_count <= lock_loss_count + 8'd1;
              state  <= S_HOLD;
              cnt    <= entry_count(S_HOLD);
              outs_q <= state_outputs(S_HOLD);
            end
          end
          S_FAIL: begin
            // Bypass clock is usable: drop system reset after the post-lock delay.
            if (cnt == '0) outs_q[2] <= 1'b0;
          end
          default: begin
            state  <= S_HOLD;
            cnt    <= entry_count(S_HOLD);
            outs_q <= state_outputs(S_HOLD);
          end
        endcase
      end
    end
  end

endmodule
